// File: rtl/timer_bank_if.sv
// CPU data-bus bundle for timer_bank: read/write strobes, byte address,
// write data and combinational read data.
interface timer_bank_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH memory-mapped reload counters with write-1-to-clear
// interrupt pending bits and a combined irqout.
// Optional feature: define TIMER_PRESCALE_EN to add a per-channel 8-bit
// prescaler (PSC register at channel offset +C).
module timer_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic              clk,
  input  logic              reset,
  timer_bank_if.slave       bus,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irqout
);

  typedef enum logic [1:0] {
    R_TH   = 2'd0,
    R_TL   = 2'd1,
    R_TCON = 2'd2,
    R_PSC  = 2'd3
  } reg_e;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic [CNT_W-1:0]  th [NUM_CH];
  logic [CNT_W-1:0]  tl [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] ie;
  logic [NUM_CH-1:0] oneshot;
  logic [NUM_CH-1:0] pend;

  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] ovf;

  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] wr_th;
  logic [NUM_CH-1:0] wr_tl;
  logic [NUM_CH-1:0] wr_tcon;
  logic              wr_stat;

  logic              page_hit;
  logic              in_ch;
  logic              stat_hit;
  logic [2:0]        ch_idx;
  reg_e              reg_sel;

  assign page_hit = (bus.addr[1:0] == 2'b00) && (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign in_ch    = page_hit && !bus.addr[7];
  assign stat_hit = page_hit && (bus.addr[7:0] == 8'h80);
  assign ch_idx   = bus.addr[6:4];
  assign reg_sel  = reg_e'(bus.addr[3:2]);
  assign wr_stat  = bus.wr && stat_hit;

  // Channel select and per-register write strobes
  always_comb begin
    ch_sel  = '0;
    wr_th   = '0;
    wr_tl   = '0;
    wr_tcon = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      ch_sel[n]  = in_ch && (ch_idx == 3'(n));
      wr_th[n]   = ch_sel[n] && bus.wr && (reg_sel == R_TH);
      wr_tl[n]   = ch_sel[n] && bus.wr && (reg_sel == R_TL);
      wr_tcon[n] = ch_sel[n] && bus.wr && (reg_sel == R_TCON);
    end
  end

`ifdef TIMER_PRESCALE_EN
  logic [7:0]        psc     [NUM_CH];
  logic [7:0]        psc_cnt [NUM_CH];
  logic [NUM_CH-1:0] wr_psc;

  // PSC write strobes and tick when the prescale counter reaches PSC
  always_comb begin
    wr_psc = '0;
    tick   = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      wr_psc[n] = ch_sel[n] && bus.wr && (reg_sel == R_PSC);
      tick[n]   = en[n] && (psc_cnt[n] == psc[n]);
    end
  end

  // Prescale counters: restart on PSC write or EN rising, wrap after PSC
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        psc[n]     <= '0;
        psc_cnt[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (wr_psc[n])
          psc[n] <= bus.wdata[7:0];
        if (wr_psc[n] || (wr_tcon[n] && bus.wdata[0] && !en[n]))
          psc_cnt[n] <= '0;
        else if (en[n])
          psc_cnt[n] <= tick[n] ? 8'd0 : psc_cnt[n] + 8'd1;
      end
    end
  end
`else
  assign tick = en;
`endif

  // A TCON write clearing EN suppresses that edge's tick; a CPU TL write
  // cancels any overflow from the same edge (no reload, no PEND, no stop)
  always_comb begin
    run = '0;
    ovf = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      run[n] = tick[n] && !(wr_tcon[n] && !bus.wdata[0]);
      ovf[n] = run[n] && (tl[n] == ALL_ONES) && !wr_tl[n];
    end
  end

  // Counter, reload, control and pending state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        th[n] <= '0;
        tl[n] <= '0;
      end
      en      <= '0;
      ie      <= '0;
      oneshot <= '0;
      pend    <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (wr_th[n])
          th[n] <= bus.wdata[CNT_W-1:0];

        if (wr_tl[n])
          tl[n] <= bus.wdata[CNT_W-1:0];
        else if (ovf[n])
          tl[n] <= th[n];
        else if (run[n])
          tl[n] <= tl[n] + CNT_W'(1);

        // A one-shot overflow consumes the mode: EN and ONESHOT both drop,
        // leaving only IE/PEND visible in TCON
        if (wr_tcon[n]) begin
          en[n]      <= bus.wdata[0];
          ie[n]      <= bus.wdata[1];
          oneshot[n] <= bus.wdata[3];
        end else if (ovf[n] && oneshot[n]) begin
          en[n]      <= 1'b0;
          oneshot[n] <= 1'b0;
        end

        pend[n] <= (ovf[n] && ie[n]) || (pend[n] && !(wr_stat && bus.wdata[n]));
      end
    end
  end

  assign irq_vec = pend;
  assign irqout  = |pend;

  // Combinational read mux, zero when idle or unmapped
  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (stat_hit)
        bus.rdata[NUM_CH-1:0] = pend;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (ch_sel[n]) begin
          case (reg_sel)
            R_TH:    bus.rdata[CNT_W-1:0] = th[n];
            R_TL:    bus.rdata[CNT_W-1:0] = tl[n];
            R_TCON:  bus.rdata[3:0] = {oneshot[n], pend[n], ie[n], en[n]};
`ifdef TIMER_PRESCALE_EN
            R_PSC:   bus.rdata[7:0] = psc[n];
`endif
            default: bus.rdata = '0;
          endcase
        end
      end
    end
  end

endmodule
